// File: rtl/count_enable_gen.sv
// Count-enable pacing stage: emits one-cycle enable strobes every max(divisor,1) cycles
// in continuous, burst or single-shot runs, with busy/done status and a saturating strobe count.
module count_enable_gen #(
   parameter int DIV_WIDTH   = 16,
   parameter int BURST_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   stop,
   input  logic [1:0]             mode,
   input  logic [DIV_WIDTH-1:0]   divisor,
   input  logic [BURST_WIDTH-1:0] burst_len,
   output logic                   enable_out,
   output logic                   busy,
   output logic                   done,
   output logic [BURST_WIDTH-1:0] pulses_issued,
   output logic [1:0]             dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [DIV_WIDTH-1:0]   presc_q, presc_d;
   logic [BURST_WIDTH-1:0] count_q, count_d;
   logic                   enable_q, enable_d;
   logic                   last_q, last_d;
   logic [1:0]             mode_q, mode_d;
   logic [DIV_WIDTH-1:0]   div_q, div_d;
   logic [BURST_WIDTH-1:0] len_q, len_d;

   // On the accepting edge the live inputs stand in for the not-yet-latched config.
   logic                   in_idle;
   logic [1:0]             mode_cur;
   logic [DIV_WIDTH-1:0]   div_cur;
   logic [BURST_WIDTH-1:0] len_cur;
   logic [DIV_WIDTH-1:0]   div_lim;
   logic [DIV_WIDTH-1:0]   presc_cur;
   logic [DIV_WIDTH-1:0]   presc_adv;
   logic [BURST_WIDTH-1:0] count_cur;
   logic [BURST_WIDTH-1:0] count_inc;
   logic [BURST_WIDTH-1:0] target;
   logic                   term;
   logic                   ends_now;

   assign in_idle   = (state_q == S_IDLE);
   assign mode_cur  = in_idle ? mode      : mode_q;
   assign div_cur   = in_idle ? divisor   : div_q;
   assign len_cur   = in_idle ? burst_len : len_q;
   assign div_lim   = (div_cur == '0) ? '0 : div_cur - DIV_WIDTH'(1);
   assign presc_cur = (state_q == S_RUN) ? presc_q : '0;
   assign count_cur = (state_q == S_RUN) ? count_q : '0;
   assign term      = (presc_cur == div_lim);
   assign presc_adv = term ? '0 : presc_cur + DIV_WIDTH'(1);
   assign count_inc = (&count_cur) ? count_cur : count_cur + BURST_WIDTH'(1);
   assign target    = (mode_cur == 2'd1) ? len_cur : BURST_WIDTH'(1);
   assign ends_now  = (mode_cur != 2'd0) && (count_inc == target);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         presc_q  <= '0;
         count_q  <= '0;
         enable_q <= 1'b0;
         last_q   <= 1'b0;
         mode_q   <= '0;
         div_q    <= '0;
         len_q    <= '0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         count_q  <= count_d;
         enable_q <= enable_d;
         last_q   <= last_d;
         mode_q   <= mode_d;
         div_q    <= div_d;
         len_q    <= len_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      count_d  = count_q;
      enable_d = 1'b0;
      last_d   = 1'b0;
      mode_d   = mode_q;
      div_d    = div_q;
      len_d    = len_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               mode_d  = mode;
               div_d   = divisor;
               len_d   = burst_len;
               count_d = '0;
               presc_d = '0;
               if (mode == 2'd1 && burst_len == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
                  presc_d = presc_adv;
                  if (term) begin
                     enable_d = 1'b1;
                     count_d  = count_inc;
                     last_d   = ends_now;
                  end
               end
            end
         end
         S_RUN: begin
            // last_q marks the cycle showing the final strobe; a stop here also drops any due strobe.
            if (stop || last_q) begin
               state_d = S_DONE;
               presc_d = '0;
            end else begin
               presc_d = presc_adv;
               if (term) begin
                  enable_d = 1'b1;
                  count_d  = count_inc;
                  last_d   = ends_now;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      enable_out    = enable_q;
      busy          = (state_q == S_RUN);
      done          = (state_q == S_DONE);
      pulses_issued = count_q;
      dbg_state_o   = state_q;
   end

endmodule

// File: tb/tb_count_enable_gen.sv
// Bench for count_enable_gen: a run model predicts strobe/done events into a queue that a
// monitor checks whenever the DUT shows enable_out or done; busy is checked every cycle.
module tb_count_enable_gen;

   localparam int EW = 42; // {kind[1:0], label cycle[31:0], expected pulses_issued[7:0]}

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [1:0] mode = '0;
   logic [15:0] divisor = '0;
   logic [7:0] burst_len = '0;
   logic       enable_out, busy, done;
   logic [7:0] pulses_issued;
   logic [1:0] dbg_state;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int run_t = -100;
   int run_e = 0;
   logic mon_en = 1'b0;
   logic [EW-1:0] exp_q[$];

   count_enable_gen #(.DIV_WIDTH(16), .BURST_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
      .divisor(divisor), .burst_len(burst_len), .enable_out(enable_out),
      .busy(busy), .done(done), .pulses_issued(pulses_issued), .dbg_state_o(dbg_state)
   );

   // clock / cycle counter: after edge n, cyc == n and the visible outputs are "label n+1"
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin : monitor
      int label;
      logic [EW-1:0] ev;
      logic exp_busy;
      if (mon_en) begin
         label = cyc + 1;
         while (exp_q.size() > 0 && int'(exp_q[0][39:8]) < label) begin
            ev = exp_q.pop_front();
            tests++;
            fails++;
            $display("FAIL missed_event kind %0d: expected at cycle %0d, not seen", ev[41:40], ev[39:8]);
         end
         exp_busy = (label >= run_t + 1) && (label <= run_t + run_e);
         check("busy", busy, exp_busy);
         if (enable_out || done) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_event at cycle %0d: enable_out=%0b done=%0b, none expected", label, enable_out, done);
            end else begin
               ev = exp_q.pop_front();
               check("event_kind", {done, enable_out}, ev[41:40]);
               check("event_cycle", label, ev[39:8]);
               check("event_count", pulses_issued, ev[7:0]);
            end
         end
      end
   end

   // Model: run ends at offset E = min(stop edge, D*target); strobes at T+D*i for D*i <= E,
   // busy over T+1..T+E, done at T+E+1, count saturating at 255.
   task automatic run(input logic [1:0] m, input int dv, input int ln, input int k);
      int d, fin, e, n;
      d = (dv == 0) ? 1 : dv;
      if (m == 2'd0) fin = 1 << 30;
      else if (m == 2'd1) fin = d * ln;
      else fin = d;
      e = (k > 0 && k < fin) ? k : fin;
      tick();
      run_t = cyc + 1;
      run_e = e;
      n = 0;
      for (int i = 1; d * i <= e; i++) begin
         n = (i > 255) ? 255 : i;
         exp_q.push_back({2'b01, 32'(run_t + d * i), 8'(n)});
      end
      exp_q.push_back({2'b10, 32'(run_t + e + 1), 8'(n)});
      start = 1'b1;
      stop = 1'b0;
      mode = m;
      divisor = 16'(dv);
      burst_len = 8'(ln);
      for (int j = 1; j <= e + 2; j++) begin
         tick();
         start = (j <= e + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         stop = (j == k);
         mode = 2'($urandom);
         divisor = 16'($urandom_range(0, 8));
         burst_len = 8'($urandom);
      end
      tick();
      start = 1'b0;
      stop = 1'b0;
      check("hold_count", pulses_issued, n);
      check("idle_after_run", dbg_state, 0);
      check("queue_drained", exp_q.size(), 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL timeout: simulation did not finish, got %0d cycles expected fewer", cyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int m, dv, ln, k, fin;
      reset = 1'b1;
      tick();
      tick();
      check("reset_state", {enable_out, busy, done, pulses_issued, dbg_state}, 0);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_outputs", {enable_out, busy, done, pulses_issued, dbg_state}, 0);
      end
      mon_en = 1'b1;

      run(2'd0, 4, 0, 13);   // continuous D=4, stop at T+13
      run(2'd1, 3, 5, 0);    // burst of 5, D=3
      run(2'd2, 0, 0, 0);    // single-shot, divisor 0
      run(2'd1, 5, 0, 0);    // burst_len 0
      run(2'd3, 0, 0, 0);    // reserved mode = single-shot
      run(2'd3, 6, 9, 0);
      run(2'd2, 6, 9, 0);
      run(2'd0, 2, 0, 5);    // stop on a terminal cycle
      run(2'd0, 1, 0, 300);  // count saturation

      // start and stop together in IDLE: nothing happens
      tick();
      start = 1'b1;
      stop = 1'b1;
      mode = 2'd0;
      divisor = 16'd1;
      tick();
      start = 1'b0;
      stop = 1'b0;
      tick();
      tick();
      check("start_stop_idle", {busy, dbg_state}, 0);

      // reset in mid-burst
      mon_en = 1'b0;
      start = 1'b1;
      mode = 2'd1;
      divisor = 16'd2;
      burst_len = 8'd10;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("busy_before_reset", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_reset_outputs", {enable_out, busy, done, pulses_issued, dbg_state}, 0);
      tick();
      check("post_reset_idle", {enable_out, busy, done, pulses_issued, dbg_state}, 0);
      exp_q.delete();
      run_t = -100;
      mon_en = 1'b1;
      run(2'd1, 3, 2, 0);

      for (int r = 0; r < 25; r++) begin
         m = $urandom_range(0, 3);
         dv = $urandom_range(0, 6);
         ln = $urandom_range(0, 6);
         fin = (dv == 0 ? 1 : dv) * ((m == 1) ? ln : 1);
         if (m == 0) k = $urandom_range(1, 30);
         else if ($urandom_range(0, 1) == 0) k = 0;
         else k = $urandom_range(1, fin + 2);
         run(2'(m), dv, ln, k);
      end

      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
